// File: rtl/deferred_report_sched.sv
// Round-robin collector for deferred-assertion failure reports.
// Records wait in a circular buffer until settle matures or flush discards them.
module deferred_report_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ID_W-1:0]      req_id,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       flush,
  input  logic                       settle,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [ID_W-1:0]            rpt_id,
  output logic [$clog2(N_REQ)-1:0]   rpt_src,
  output logic [$clog2(DEPTH):0]     pend_cnt,
  output logic [15:0]                flushed_cnt
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int ENT_W = SRC_W + ID_W;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    mat_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [SRC_W-1:0] last_grant;
  logic [ENT_W-1:0] mem [DEPTH];

  logic [ID_W-1:0]  ids [N_REQ];
  logic [PW-1:0]    occ;
  logic             full;
  logic             found;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W:0]   cand;
  logic             accept;
  logic             drain;
  logic [16:0]      fsum;

  for (genvar i = 0; i < N_REQ; i++) begin : g_ids
    assign ids[i] = req_id[i*ID_W +: ID_W];
  end

  assign occ  = wr_ptr - rd_ptr;
  assign full = (occ == PW'(DEPTH));

  // First valid requester strictly after last_grant, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = last_grant;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(N_REQ))
        cand = cand - (SRC_W+1)'(N_REQ);
      if (!found && req_valid[cand[SRC_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && !full && !flush)
      req_ready[gnt_idx] = 1'b1;
  end

  assign accept    = |(req_valid & req_ready);
  assign rpt_valid = (rd_ptr != mat_ptr);
  assign drain     = rpt_valid & rpt_ready;
  assign {rpt_src, rpt_id} = mem[rd_ptr[AW-1:0]];
  assign pend_cnt  = wr_ptr - mat_ptr;
  assign fsum      = {1'b0, flushed_cnt} + 17'(pend_cnt);

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr[AW-1:0]] <= {gnt_idx, ids[gnt_idx]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      mat_ptr     <= '0;
      rd_ptr      <= '0;
      last_grant  <= SRC_W'(N_REQ-1);
      flushed_cnt <= '0;
    end else begin
      if (flush) begin
        wr_ptr      <= mat_ptr;
        flushed_cnt <= fsum[16] ? 16'hFFFF : fsum[15:0];
      end else begin
        if (settle)
          mat_ptr <= wr_ptr;
        if (accept) begin
          wr_ptr     <= wr_ptr + PW'(1);
          last_grant <= gnt_idx;
        end
      end
      if (drain)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_deferred_report_sched.sv
// Randomized and directed bench for deferred_report_sched.
// A queue-based model of pending/matured records predicts every output.
module tb_deferred_report_sched;

  localparam int N_REQ = 4;
  localparam int ID_W  = 8;
  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*ID_W-1:0] req_id;
  logic [N_REQ-1:0]      req_ready;
  logic                  flush;
  logic                  settle;
  logic                  rpt_valid;
  logic                  rpt_ready;
  logic [ID_W-1:0]       rpt_id;
  logic [1:0]            rpt_src;
  logic [3:0]            pend_cnt;
  logic [15:0]           flushed_cnt;

  deferred_report_sched #(
    .N_REQ(N_REQ), .ID_W(ID_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
    .flush(flush), .settle(settle),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_id(rpt_id), .rpt_src(rpt_src),
    .pend_cnt(pend_cnt), .flushed_cnt(flushed_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Model: each record is src*256 + id
  int pend_q[$];
  int mat_q[$];
  int last_g = N_REQ - 1;
  int flushed = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [N_REQ-1:0] v,
                      input logic [N_REQ*ID_W-1:0] ids,
                      input logic f, input logic s, input logic rr);
    int g;
    int c;
    logic [N_REQ-1:0] exp_rdy;
    @(negedge clk);
    rst = r; req_valid = v; req_id = ids;
    flush = f; settle = s; rpt_ready = rr;
    #1;
    g = -1;
    if (pend_q.size() + mat_q.size() < DEPTH && !f)
      for (int k = 1; k <= N_REQ; k++) begin
        c = (last_g + k) % N_REQ;
        if (g < 0 && v[c]) g = c;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rpt_valid", 32'(rpt_valid), 32'(mat_q.size() != 0));
      if (mat_q.size() != 0) begin
        chk("rpt_id", 32'(rpt_id), 32'(mat_q[0] % 256));
        chk("rpt_src", 32'(rpt_src), 32'(mat_q[0] / 256));
      end
      chk("pend_cnt", 32'(pend_cnt), 32'(pend_q.size()));
      chk("flushed_cnt", 32'(flushed_cnt), 32'(flushed));
    end
    if (r) begin
      pend_q.delete(); mat_q.delete();
      last_g = N_REQ - 1; flushed = 0; chk_en = 1;
    end else begin
      if (rr && mat_q.size() != 0) void'(mat_q.pop_front());
      if (f) begin
        flushed = flushed + pend_q.size();
        if (flushed > 65535) flushed = 65535;
        pend_q.delete();
      end else begin
        if (s) begin
          foreach (pend_q[i]) mat_q.push_back(pend_q[i]);
          pend_q.delete();
        end
        if (g >= 0) begin
          pend_q.push_back(g * 256 + int'(ids[g*ID_W +: ID_W]));
          last_g = g;
        end
      end
    end
  endtask

  function automatic logic [N_REQ*ID_W-1:0] rnd_ids();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, rr);
  endtask

  task automatic enq(input int n, input logic s, input logic rr);
    for (int i = 0; i < n; i++) step(0, 4'hF, rnd_ids(), 0, s, rr);
  endtask

  initial begin
    rst = 1; req_valid = '0; req_id = '0;
    flush = 0; settle = 0; rpt_ready = 0;
    step(1, '0, '0, 0, 0, 0);
    idle(1, 0);

    // single record from checker 2
    step(0, 4'b0100, 32'h0015_0000, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0);
    idle(2, 0);
    idle(2, 1);

    // round-robin, then drain in order
    enq(8, 0, 0);
    step(0, '0, '0, 0, 1, 0);
    idle(10, 1);

    // flush with matured records ahead of it
    enq(2, 0, 0);
    step(0, '0, '0, 0, 1, 0);
    enq(3, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    idle(4, 1);

    // settle+flush together, accept with settle
    enq(2, 0, 1);
    step(0, '0, '0, 1, 1, 1);
    step(0, 4'b0010, rnd_ids(), 0, 1, 1);
    idle(2, 1);
    step(0, '0, '0, 0, 1, 1);
    idle(3, 1);

    // full with backpressure, release, then wrap
    enq(10, 0, 0);
    step(0, '0, '0, 0, 1, 0);
    enq(3, 0, 0);
    enq(12, 0, 1);
    for (int i = 0; i < 30; i++) enq(1, (i % 3) == 0, 1);
    step(0, '0, '0, 0, 1, 1);
    idle(12, 1);

    // reset with matured and pending records
    enq(4, 0, 0);
    step(0, '0, '0, 0, 1, 0);
    enq(2, 0, 0);
    step(1, '0, '0, 0, 0, 0);
    idle(2, 1);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 499) == 0),
           4'($urandom),
           rnd_ids(),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0));
    idle(20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
